// File: rtl/stream_packer_if.sv
// Handshake bundle for stream_packer: narrow beat input side and wide word output side.
// The slave modport is the packer's view; master is the driving environment's view.
interface stream_packer_if #(
    parameter int DataWidth = 8,
    parameter int Beats     = 4
);
    logic                       s_valid_i;
    logic                       s_ready_o;
    logic [DataWidth-1:0]       s_data_i;
    logic                       m_valid_o;
    logic                       m_ready_i;
    logic [DataWidth*Beats-1:0] m_data_o;

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o,
        output m_valid_o,
        output m_data_o,
        input  m_ready_i
    );

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o,
        input  m_valid_o,
        input  m_data_o,
        output m_ready_i
    );
endinterface

// File: rtl/stream_packer.sv
// Packs Beats consecutive DataWidth-bit beats into one little-endian word.
// Optional partial-word flush enabled by defining STREAM_PACKER_FLUSH_EN.
module stream_packer #(
    parameter int DataWidth = 8,
    parameter int Beats     = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
`ifdef STREAM_PACKER_FLUSH_EN
    input  logic                     flush_i,
    output logic [$clog2(Beats):0]   m_count_o,
`endif
    stream_packer_if.slave           bus
);
    localparam int CW = $clog2(Beats);
    localparam int WW = DataWidth * Beats;
    localparam logic [CW-1:0] LAST = CW'(Beats - 1);

    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] acc_q, acc_d;
    logic [WW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic [WW-1:0] merged;
    logic          accept;
    logic          last;
    logic          out_free;

`ifdef STREAM_PACKER_FLUSH_EN
    logic          flush_pending_q, flush_pending_d;
    logic [CW:0]   m_count_q, m_count_d;
    logic [CW:0]   fill;
`endif

    assign last     = (count_q == LAST);
    assign out_free = ~m_valid_q | bus.m_ready_i;

    // Only the final beat needs a free output slot; partial beats always fit.
    assign bus.s_ready_o = reset_i & ~(last & m_valid_q & ~bus.m_ready_i);
    assign accept        = bus.s_valid_i & bus.s_ready_o;

    assign bus.m_valid_o = m_valid_q;
    assign bus.m_data_o  = m_data_q;

    always_comb begin
        merged = acc_q;
        for (int b = 0; b < Beats; b++) begin
            if (accept && count_q == CW'(b)) begin
                merged[b*DataWidth +: DataWidth] = bus.s_data_i;
            end
        end
    end

`ifdef STREAM_PACKER_FLUSH_EN
    assign fill      = {1'b0, count_q} + {{CW{1'b0}}, accept};
    assign m_count_o = m_count_q;
`endif

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q & ~bus.m_ready_i;
`ifdef STREAM_PACKER_FLUSH_EN
        m_count_d       = m_count_q;
        flush_pending_d = flush_pending_q | flush_i;
`endif
        if (accept && last) begin
            m_data_d  = merged;
            m_valid_d = 1'b1;
            count_d   = '0;
            acc_d     = '0;
`ifdef STREAM_PACKER_FLUSH_EN
            m_count_d       = (CW+1)'(Beats);
            flush_pending_d = 1'b0;
`endif
        end else begin
            if (accept) begin
                acc_d   = merged;
                count_d = count_q + CW'(1);
            end
`ifdef STREAM_PACKER_FLUSH_EN
            // Upper slots of acc_q are already zero, so merged is the padded word.
            if (flush_pending_d && out_free) begin
                if (fill != '0) begin
                    m_data_d  = merged;
                    m_valid_d = 1'b1;
                    m_count_d = fill;
                    count_d   = '0;
                    acc_d     = '0;
                end
                flush_pending_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            count_q   <= '0;
            acc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
            m_count_q       <= (CW+1)'(Beats);
            flush_pending_q <= 1'b0;
`endif
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
`ifdef STREAM_PACKER_FLUSH_EN
            m_count_q       <= m_count_d;
            flush_pending_q <= flush_pending_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (DataWidth=8, Beats=4).
// Flush scenarios are included when STREAM_PACKER_FLUSH_EN is defined.
module tb_stream_packer;
    localparam int DW = 8;
    localparam int NB = 4;

    logic clk;
    logic rst_n;
    logic flush;
    logic [2:0] m_count;

    stream_packer_if #(.DataWidth(DW), .Beats(NB)) bus ();

    stream_packer #(.DataWidth(DW), .Beats(NB)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
`ifdef STREAM_PACKER_FLUSH_EN
        .flush_i   (flush),
        .m_count_o (m_count),
`endif
        .bus     (bus)
    );

`ifndef STREAM_PACKER_FLUSH_EN
    assign m_count = 3'(NB);
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          sv;
        logic [7:0]  sd;
        bit          mr;
        bit          fl;
        bit          er;
        bit          ev;
        bit          cd;
        logic [31:0] ed;
        int          ec;
    } vec_t;

    vec_t tbl[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain byte queue plus one output slot.
    logic [7:0]  part[$];
    bit          mv;
    logic [31:0] md;
    int          mc;
    bit          pend;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic v(input bit rst, input bit sv, input logic [7:0] sd,
                     input bit mr, input bit fl, input bit er, input bit ev,
                     input bit cd, input logic [31:0] ed, input int ec);
        vec_t r;
        r.rst = rst; r.sv = sv; r.sd = sd; r.mr = mr; r.fl = fl;
        r.er = er; r.ev = ev; r.cd = cd; r.ed = ed; r.ec = ec;
        tbl.push_back(r);
    endtask

    task automatic drive(input bit rst, input bit sv, input logic [7:0] sd,
                         input bit mr, input bit fl);
        rst_n         = rst;
        bus.s_valid_i = sv;
        bus.s_data_i  = sd;
        bus.m_ready_i = mr;
        flush         = fl;
    endtask

    function automatic bit model_ready(input bit rst, input bit mr);
        return rst && !(part.size() == NB - 1 && mv && !mr);
    endfunction

    function automatic logic [31:0] pack_part();
        logic [31:0] w;
        w = '0;
        foreach (part[i]) w[i*8 +: 8] = part[i];
        return w;
    endfunction

    task automatic model_step(input bit rst, input bit sv,
                              input logic [7:0] sd, input bit mr,
                              input bit fl, input bit rdy);
        bit free;
        if (!rst) begin
            part.delete();
            mv = 0; md = '0; mc = NB; pend = 0;
            return;
        end
        free = !mv || mr;
        if (mv && mr) mv = 0;
        if (sv && rdy) part.push_back(sd);
        pend = pend | fl;
        if (part.size() == NB) begin
            md = pack_part(); mv = 1; mc = NB;
            part.delete();
            pend = 0;
        end else if (pend && free) begin
            if (part.size() > 0) begin
                md = pack_part(); mv = 1; mc = part.size();
                part.delete();
            end
            pend = 0;
        end
    endtask

    initial begin
        drive(0, 0, 8'h00, 0, 0);

        // Reset state
        v(0,0,8'h00,0,0, 0,0,1,32'h0,NB);
        v(0,1,8'h5A,1,0, 0,0,1,32'h0,NB);
        // Single word
        v(1,1,8'h11,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h22,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h33,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h44,1,0, 1,1,0,32'h44332211,NB);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
        // Streaming 0x00..0x07
        for (int i = 0; i < 8; i++)
            v(1,1,8'(i),1,0, 1,(i%4)==3,0,
              (i == 3) ? 32'h03020100 : 32'h07060504, NB);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
        // Backpressure
        for (int i = 0; i < 7; i++)
            v(1,1,8'(i),0,0, 1,i>=3,0,32'h03020100,NB);
        v(1,1,8'h07,0,0, 0,1,0,32'h03020100,NB);
        v(1,1,8'h07,0,0, 0,1,0,32'h03020100,NB);
        v(1,1,8'h07,1,0, 1,1,0,32'h07060504,NB);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
        // Reset mid-word
        v(1,1,8'hEE,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'hFF,1,0, 1,0,0,32'h0,NB);
        v(0,1,8'hEE,1,0, 0,0,1,32'h0,NB);
        v(1,1,8'hA0,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'hA1,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'hA2,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'hA3,1,0, 1,1,0,32'hA3A2A1A0,NB);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
`ifdef STREAM_PACKER_FLUSH_EN
        // Partial flush, empty flush, flush with the final beat
        v(1,1,8'h55,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h66,1,0, 1,0,0,32'h0,NB);
        v(1,0,8'h00,1,1, 1,1,0,32'h00006655,2);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
        v(1,0,8'h00,1,1, 1,0,0,32'h0,NB);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h11,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h22,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h33,1,0, 1,0,0,32'h0,NB);
        v(1,1,8'h44,1,1, 1,1,0,32'h44332211,4);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
        v(1,0,8'h00,1,0, 1,0,0,32'h0,NB);
`endif

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d s_ready", i), 32'(bus.s_ready_o),
                32'(tbl[i].er));
            @(posedge clk); #1;
            chk($sformatf("vec%0d m_valid", i), 32'(bus.m_valid_o),
                32'(tbl[i].ev));
            if (tbl[i].ev || tbl[i].cd)
                chk($sformatf("vec%0d m_data", i), bus.m_data_o, tbl[i].ed);
`ifdef STREAM_PACKER_FLUSH_EN
            if (tbl[i].ev)
                chk($sformatf("vec%0d m_count", i), 32'(m_count),
                    32'(tbl[i].ec));
`endif
        end

        // Randomized run against the queue model, starting from reset
        model_step(0, 0, 8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            bit rst, sv, mr, fl, rdy;
            logic [7:0] sd;
            rst = ($urandom_range(0, 199) != 0);
            sv  = ($urandom_range(0, 3) != 0);
            sd  = 8'($urandom);
            mr  = (c % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                  : ($urandom_range(0, 3) == 0);
`ifdef STREAM_PACKER_FLUSH_EN
            fl  = ($urandom_range(0, 11) == 0);
`else
            fl  = 0;
`endif
            drive(rst, sv, sd, mr, fl);
            rdy = model_ready(rst, mr);
            #1;
            chk("rand s_ready", 32'(bus.s_ready_o), 32'(rdy));
            model_step(rst, sv, sd, mr, fl, rdy);
            @(posedge clk); #1;
            chk("rand m_valid", 32'(bus.m_valid_o), 32'(mv));
            if (mv) begin
                chk("rand m_data", bus.m_data_o, md);
                chk("rand m_count", 32'(m_count), 32'(mc));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
